rca_result_collector: RTL and testbench
=======================================

RCA_RESULT_COLLECTOR -- requirements
Module: rca_result_collector

Interface
REQ-001 SHALL have parameter DEPTH, default MAX_IDS, meaning entries in each of the ID and result queues (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the stall threshold for the timeout detector.
REQ-003 SHALL have port clk  in  1  meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  in  1  meaning reset; synchronous and active-high.
REQ-005 SHALL have port issue_valid  in  1  meaning an instruction was issued to the grid slot this cycle.
REQ-006 SHALL have port issue_id  in  ID_W  meaning the instruction ID of the issued instruction.
REQ-007 SHALL have port issue_ready  out  1  meaning the ID queue is not full.
REQ-008 SHALL have port slot_data  in  XLEN  meaning the result word from the slot.
REQ-009 SHALL have port slot_valid  in  1  meaning slot_data is valid; there is no backpressure and the value is a one-cycle pulse per result.
REQ-010 SHALL have port wb_done  out  1  meaning a writeback result is presented.
REQ-011 SHALL have port wb_rd  out  XLEN  meaning the result data.
REQ-012 SHALL have port wb_id  out  ID_W  meaning the ID paired with wb_rd.
REQ-013 SHALL have port wb_ack  in  1  meaning the writeback consumer accepts this cycle.
REQ-014 SHALL have port overflow_err  out  1  meaning sticky: a result was dropped.
REQ-015 SHALL have port timeout_err  out  1  meaning sticky: the timeout detector fired.

Function
REQ-016 SHALL push issue_id into an in-order ID queue at the edge ending any cycle where issue_valid=1 and issue_ready=1; issue_valid while not ready is ignored.
REQ-017 SHALL push slot_data into an in-order result queue at the edge ending any cycle where slot_valid=1 and the result queue is not full.
REQ-018 SHALL drop slot_data when slot_valid=1 and the result queue is full, and set overflow_err=1 until reset.
REQ-019 SHALL pair entries strictly in FIFO order: the k-th result returned is tagged with the k-th issued ID.
REQ-020 SHALL load a single output register, popping both queues in the same cycle, when both queues are non-empty and (wb_done=0 or wb_ack=1).
REQ-021 SHALL hold wb_done, wb_rd and wb_id stable while wb_done=1 and wb_ack=0.
REQ-022 SHALL clear wb_done after an acknowledged cycle unless a new pair loads in that same cycle, giving back-to-back throughput of 1 result/cycle.
REQ-023 SHALL present a result with wb_done=1 two cycles after its slot_valid cycle when the ID is already queued and the output register is free.
REQ-024 SHALL allow push and pop of the same queue in one cycle while the queue is full; the occupancy is unchanged and no overflow is flagged.
REQ-025 SHALL wrap the queue pointers modulo DEPTH, with full/empty derived from an occupancy count of width $clog2(DEPTH)+1.
REQ-026 SHALL ignore wb_ack while wb_done=0.

Reset
REQ-027 SHALL, on rst=1, empty both queues, set wb_done=0, wb_rd=0, wb_id=0, overflow_err=0, timeout_err=0, clear the timeout counter, and drive issue_ready=1 from the first cycle after reset.
REQ-028 SHALL discard any in-flight result or ID when reset is asserted mid-operation; slot_valid and issue_valid are ignored during reset cycles.

Configuration
REQ-029 SHALL, with macro RCA_COLLECTOR_TIMEOUT_EN defined, count consecutive cycles in which the ID queue is non-empty and no pop occurs, reset the count on any pop, and set timeout_err=1 (sticky) when the count reaches TIMEOUT_CYCLES.
REQ-030 SHALL, without RCA_COLLECTOR_TIMEOUT_EN, contain no counter and tie timeout_err to 0.

Structure
REQ-031 SHALL take XLEN from taiga_config and MAX_IDS from taiga_types, and SHALL take ID_W (=$clog2(MAX_IDS)) and a packed rca_result_t {id, data} typedef from rca_config.
REQ-032 SHALL implement each queue as an instance of one sub-module, rca_sync_queue (parameterised width/depth, push/pop/full/empty/data_out), instantiated once for IDs and once for data.

Verification
REQ-033 SHALL verify: issue id=3, then 2 cycles later slot_valid with data=0xDEADBEEF, wb_ack tied 1 -> wb_done=1 with wb_id=3 and wb_rd=0xDEADBEEF exactly 2 cycles after slot_valid, for one cycle.
REQ-034 SHALL verify: issue ids 1,2,3, return results 0xA,0xB,0xC, wb_ack=0 for 5 cycles then 1 -> wb_id=1/wb_rd=0xA is held 5 cycles, then pairs (1,A),(2,B),(3,C) appear on consecutive cycles.
REQ-035 SHALL verify: with DEPTH=4 and wb_ack=0, issue 5 IDs and send 6 results -> issue_ready=0 after the 4th pending ID, and overflow_err=1 after the 6th result (output register holds 1 result, queue holds 4).
REQ-036 SHALL verify: queue full, with simultaneous slot_valid and pop -> no overflow, occupancy unchanged, and order preserved across pointer wrap after 10 pairs.
REQ-037 SHALL verify: rst asserted while wb_done=1 with 2 queued results -> next cycle wb_done=0, issue_ready=1, and no stale result appears after new issue id=5 / data=0x55.
REQ-038 SHALL verify: with RCA_COLLECTOR_TIMEOUT_EN and TIMEOUT_CYCLES=16, issue id=0 and send no result -> timeout_err=1 after 16 cycles; without the macro, timeout_err stays 0.

Source files
------------

// File: rtl/rca_config.sv
// Result-collector configuration: ID width and the packed writeback record.
package rca_config;

  localparam int unsigned ID_W = $clog2(taiga_types::MAX_IDS);

  typedef struct packed {
    logic [ID_W-1:0]                 id;
    logic [taiga_config::XLEN-1:0]   data;
  } rca_result_t;

endpackage

// File: rtl/taiga_config.sv
// Core-wide configuration constants shared by the collector and its clients.
package taiga_config;

  localparam int unsigned XLEN = 32;

endpackage

// File: rtl/taiga_types.sv
// Core-wide type constants: the size of the instruction-ID space.
package taiga_types;

  localparam int unsigned MAX_IDS = 8;

endpackage

// File: rtl/rca_sync_queue.sv
// Synchronous FIFO with occupancy counter. A push while full is accepted only
// when a pop happens in the same cycle, so a full queue can stream at 1/cycle.
module rca_sync_queue #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr_q];

  // Storage array; stale entries are harmless because pointers gate reads.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= din;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/rca_result_collector.sv
// Pairs in-order issued instruction IDs with in-order slot results and presents
// them through a single held writeback register.
// Optional stall detector enabled by defining RCA_COLLECTOR_TIMEOUT_EN.
module rca_result_collector
  import taiga_config::*;
  import taiga_types::*;
  import rca_config::*;
#(
  parameter int unsigned DEPTH          = MAX_IDS,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [ID_W-1:0] issue_id,
  output logic            issue_ready,
  input  logic [XLEN-1:0] slot_data,
  input  logic            slot_valid,
  output logic            wb_done,
  output logic [XLEN-1:0] wb_rd,
  output logic [ID_W-1:0] wb_id,
  input  logic            wb_ack,
  output logic            overflow_err,
  output logic            timeout_err
);

  logic            id_full;
  logic            id_empty;
  logic [ID_W-1:0] id_head;
  logic            res_full;
  logic            res_empty;
  logic [XLEN-1:0] res_head;
  logic            pop_pair;
  rca_result_t     out_q;
  logic            done_q;
  logic            overflow_q;

  assign issue_ready = ~id_full;
  // Pop both queues together whenever the output register is free or leaving.
  assign pop_pair    = ~id_empty & ~res_empty & (~done_q | wb_ack);

  rca_sync_queue #(
    .WIDTH (ID_W),
    .DEPTH (DEPTH)
  ) u_id_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (issue_valid & ~id_full),
    .pop   (pop_pair),
    .din   (issue_id),
    .dout  (id_head),
    .full  (id_full),
    .empty (id_empty)
  );

  // Result queue accepts a push while full only if a pop frees a slot.
  rca_sync_queue #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_res_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (slot_valid),
    .pop   (pop_pair),
    .din   (slot_data),
    .dout  (res_head),
    .full  (res_full),
    .empty (res_empty)
  );

  // Writeback register: load a new pair, else drop after acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
      out_q  <= '0;
    end else if (pop_pair) begin
      done_q <= 1'b1;
      out_q  <= '{id: id_head, data: res_head};
    end else if (wb_ack) begin
      done_q <= 1'b0;
    end
  end

  // Sticky flag for a result dropped against a full result queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (slot_valid && res_full && !pop_pair) begin
      overflow_q <= 1'b1;
    end
  end

  assign wb_done      = done_q;
  assign wb_rd        = out_q.data;
  assign wb_id        = out_q.id;
  assign overflow_err = overflow_q;

`ifdef RCA_COLLECTOR_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] stall_cnt_q;
  logic          timeout_q;

  // Count consecutive stalled cycles with an ID waiting; saturate at threshold.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else if (id_empty || pop_pair) begin
      stall_cnt_q <= '0;
    end else begin
      if (stall_cnt_q != TW'(TIMEOUT_CYCLES)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (stall_cnt_q == TW'(TIMEOUT_CYCLES - 1)) timeout_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_rca_result_collector.sv
// Directed bench for rca_result_collector with a pairing scoreboard.
module tb_rca_result_collector;
  import taiga_config::*;
  import rca_config::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TO_CYC = 16;
`ifdef RCA_COLLECTOR_TIMEOUT_EN
  localparam logic TO_EXP = 1'b1;
`else
  localparam logic TO_EXP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            issue_valid;
  logic [ID_W-1:0] issue_id;
  logic            issue_ready;
  logic [XLEN-1:0] slot_data;
  logic            slot_valid;
  logic            wb_done;
  logic [XLEN-1:0] wb_rd;
  logic [ID_W-1:0] wb_id;
  logic            wb_ack;
  logic            overflow_err;
  logic            timeout_err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int acc_base;

  logic [ID_W-1:0] exp_id[$];
  logic [XLEN-1:0] exp_data[$];

  rca_result_collector #(
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_id     (issue_id),
    .issue_ready  (issue_ready),
    .slot_data    (slot_data),
    .slot_valid   (slot_valid),
    .wb_done      (wb_done),
    .wb_rd        (wb_rd),
    .wb_id        (wb_id),
    .wb_ack       (wb_ack),
    .overflow_err (overflow_err),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic d, input int id, input logic [31:0] rd);
    check({tag, "_done"}, wb_done, d);
    check({tag, "_id"}, wb_id, ID_W'(id));
    check({tag, "_rd"}, wb_rd, rd);
  endtask

  // One clock cycle; called at the falling edge. Accepted results are scored.
  task automatic cyc();
    if (wb_done === 1'b1 && wb_ack === 1'b1) begin
      n_acc++;
      n_checks++;
      assert (exp_id.size() != 0 && exp_data.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected: observed id %0h rd %0h, required no result", wb_id, wb_rd);
      end
      if (exp_id.size() != 0 && exp_data.size() != 0) begin
        check("sb_id", wb_id, exp_id.pop_front());
        check("sb_rd", wb_rd, exp_data.pop_front());
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input int id, input bit accepted);
    issue_valid = 1'b1;
    issue_id    = ID_W'(id);
    if (accepted) exp_id.push_back(ID_W'(id));
    cyc();
    issue_valid = 1'b0;
  endtask

  task automatic send(input logic [XLEN-1:0] d, input bit kept);
    slot_valid = 1'b1;
    slot_data  = d;
    if (kept) exp_data.push_back(d);
    cyc();
    slot_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    exp_id.delete();
    exp_data.delete();
  endtask

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_id = '0; slot_valid = 1'b0;
    slot_data = '0; wb_ack = 1'b0;
    @(negedge clk);
    cyc();
    cyc();
    rst = 1'b0;
    check("rst_done", wb_done, 1'b0);
    check("rst_id", wb_id, '0);
    check("rst_rd", wb_rd, '0);
    check("rst_ready", issue_ready, 1'b1);
    check("rst_ovf", overflow_err, 1'b0);
    check("rst_to", timeout_err, 1'b0);

    // Basic latency: result visible two cycles after slot_valid, one cycle only.
    wb_ack = 1'b1;
    issue(3, 1);
    cyc();
    check("t1_pre", wb_done, 1'b0);
    send(32'hDEADBEEF, 1);
    check("t1_n1", wb_done, 1'b0);
    cyc();
    expect_out("t1_n2", 1'b1, 3, 32'hDEADBEEF);
    cyc();
    check("t1_n3", wb_done, 1'b0);

    // Held output under backpressure, then back-to-back drain.
    wb_ack = 1'b0;
    for (int i = 1; i <= 3; i++) issue(i, 1);
    send(32'hA, 1);
    send(32'hB, 1);
    send(32'hC, 1);
    for (int i = 0; i < 5; i++) begin
      expect_out("t2_hold", 1'b1, 1, 32'hA);
      cyc();
    end
    wb_ack = 1'b1;
    expect_out("t2_p1", 1'b1, 1, 32'hA);
    cyc();
    expect_out("t2_p2", 1'b1, 2, 32'hB);
    cyc();
    expect_out("t2_p3", 1'b1, 3, 32'hC);
    cyc();
    check("t2_end", wb_done, 1'b0);

    // Full ID queue and dropped sixth result.
    wb_ack = 1'b0;
    for (int i = 1; i <= 4; i++) issue(i, 1);
    check("t3_ready_full", issue_ready, 1'b0);
    issue(5, 0);
    for (int i = 0; i < 6; i++) begin
      check("t3_ovf_pre", overflow_err, 1'b0);
      send(XLEN'(32'h10 + i), i < 5);
    end
    check("t3_ovf", overflow_err, 1'b1);
    expect_out("t3_out", 1'b1, 1, 32'h10);
    check("t3_ready", issue_ready, 1'b1);
    wb_ack = 1'b1;
    acc_base = n_acc;
    repeat (6) cyc();
    check("t3_drained", n_acc - acc_base, 4);
    check("t3_done", wb_done, 1'b0);
    do_reset();
    check("t3_ovf_clr", overflow_err, 1'b0);

    // Result queue full with simultaneous push and pop, across pointer wrap.
    wb_ack = 1'b0;
    acc_base = n_acc;
    for (int i = 0; i < 4; i++) issue(i, 1);
    for (int i = 0; i < 5; i++) send(XLEN'(32'h100 + i), 1);
    issue(4, 1);
    expect_out("t4_full", 1'b1, 0, 32'h100);
    check("t4_ready_full", issue_ready, 1'b0);
    wb_ack = 1'b1;
    send(XLEN'(32'h105), 1);
    check("t4_ovf_s0", overflow_err, 1'b0);
    for (int k = 5; k <= 12; k++) begin
      issue_valid = 1'b1;
      issue_id    = ID_W'(k);
      exp_id.push_back(ID_W'(k));
      send(XLEN'(32'h101 + k), 1);
      issue_valid = 1'b0;
      check("t4_ovf", overflow_err, 1'b0);
      check("t4_ready", issue_ready, 1'b1);
    end
    issue(13, 1);
    repeat (8) cyc();
    check("t4_pairs", n_acc - acc_base, 14);
    check("t4_ovf_end", overflow_err, 1'b0);
    check("t4_done", wb_done, 1'b0);

    // Reset mid-operation discards everything in flight.
    wb_ack = 1'b0;
    for (int i = 1; i <= 3; i++) issue(i, 1);
    send(32'h21, 1);
    send(32'h22, 1);
    send(32'h23, 1);
    expect_out("t5_pre", 1'b1, 1, 32'h21);
    issue_valid = 1'b1; issue_id = 3'd7;
    slot_valid  = 1'b1; slot_data = 32'h99;
    do_reset();
    issue_valid = 1'b0; slot_valid = 1'b0;
    expect_out("t5_rst", 1'b0, 0, 32'h0);
    check("t5_ready", issue_ready, 1'b1);
    wb_ack = 1'b1;
    acc_base = n_acc;
    issue(5, 1);
    send(32'h55, 1);
    repeat (4) cyc();
    check("t5_one", n_acc - acc_base, 1);

    // Stall detector.
    wb_ack = 1'b0;
    check("t6_pre", timeout_err, 1'b0);
    issue(0, 1);
    repeat (15) cyc();
    check("t6_15", timeout_err, 1'b0);
    cyc();
    check("t6_16", timeout_err, TO_EXP);
    repeat (4) cyc();
    check("t6_sticky", timeout_err, TO_EXP);
    do_reset();
    check("t6_clr", timeout_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
